systolic_feeder: RTL and testbench
==================================

# systolic_feeder

Edge driver for the N×N output-stationary systolic MAC array. It holds one N×N A matrix and one N×N B matrix, loaded through a word-write port. On `start` it emits the skewed wavefronts: A rows go into the west edge and B columns into the north edge, with zero padding. It also drives the array-wide `array_en` and signals `done` once every PE accumulator holds its final C[i][j].

## Interface
- `N`, 4: array dimension (rows = columns = reduction depth); N ≥ 2.
- `W`, 8: signed element width, matching PE `A_in`/`B_in`.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `wr_en`  in  1  write strobe for matrix storage.
- `wr_sel`  in  1  0 = write A, 1 = write B.
- `wr_row`  in  clog2(N)  element row index.
- `wr_col`  in  clog2(N)  element column index.
- `wr_data`  in  W  signed element value.
- `start`  in  1  single-cycle request to begin a feed.
- `a_west`  out  N*W  row i drives bits [i*W +: W] into PE(i,0) `A_in`; registered.
- `b_north`  out  N*W  column j drives bits [j*W +: W] into PE(0,j) `B_in`; registered.
- `array_en`  out  1  drives every PE `enable`; registered.
- `busy`  out  1  high while feeding or in DONE.
- `done`  out  1  one-cycle pulse; all PE `Acc_out` values are final.

## Operation
- States: IDLE, FEED, DONE. Reset enters IDLE.
- IDLE:
  - `wr_en` writes A[wr_row][wr_col] or B[wr_row][wr_col] at the clock edge.
  - `start` moves the block to FEED with step counter t = 0.
- FEED runs steps t = 0 … 3N−1 (3N cycles), then moves to DONE.
- Values driven for step t:
  - a_west row i = A[i][t−i] if 0 ≤ t−i < N, else 0.
  - b_north col j = B[t−j][j] if 0 ≤ t−j < N, else 0.
  - `array_en` = 1.
- The last non-zero data appears at t = 2N−2. Steps 2N−1 … 3N−1 are all-zero flush cycles. They cover N−1 hops to PE(N−1,N−1) plus the PE acc_reg→Acc_out stage.
- The PE ignores A=B=0 inputs, so zero padding never corrupts an accumulator.
- DONE lasts one cycle:
  - `done` = 1, `busy` = 1, `array_en` = 0, data outputs 0.
  - Next state is IDLE.
- Writes while `busy` = 1 are ignored, and storage is unchanged. `start` while `busy` = 1 is ignored.
- Simultaneous `wr_en` and `start` in IDLE: the write completes, the feed starts, and the written value is used.
- Storage persists across feeds. Back-to-back `start` reuses the loaded matrices.
- Arithmetic: the block only moves data; there is no width change. Elements are passed bit-exact as signed W-bit.
- Reset mid-feed: all outputs and storage clear immediately. The state returns to IDLE and no `done` is issued. The array must also be reset, since its accumulators are otherwise partial.

## Timing
- Reset values: `a_west` = 0, `b_north` = 0, `array_en` = 0, `busy` = 0, `done` = 0, all A/B storage = 0, t = 0.
- `start` sampled high at edge k → outputs for step t are visible after edge k+1+t, for t = 0 … 3N−1.
- `done` is high for the cycle after edge k+3N+1. Total latency from `start` to `done` is 3N+1 cycles.
- `busy` rises after edge k+1 and falls after edge k+3N+2.
- Earliest next `start` is accepted at edge k+3N+2, in IDLE.
- PE(i,j) receives the A[i][kk]/B[kk][j] pair at step i+j+kk. The array needs no further alignment logic.
- A write at edge e is visible to a feed whose `start` is sampled at edge e or later.

## Test plan
- **Skew pattern**, N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start:
  - t0: a=(1,0), b=(5,0).
  - t1: a=(2,3), b=(7,6).
  - t2: a=(0,4), b=(0,8).
  - t3–t5: all 0 with `array_en` = 1.
  - `done` one cycle later.
- **End-to-end with a 2×2 PE array**, same matrices: at `done`, Acc_out = [[19,22],[43,50]].
- **Signed extremes**, N=2: A all −128, B all 127 → every output element passes bit-exact (0x80 / 0x7F); array result is −32512 in every PE.
- **Ignored requests**: `wr_en` writing A[0][0]=9 and a second `start`, both during FEED → A[0][0] stays 1 on the next feed; exactly one `done` is issued.
- **Reset mid-feed** at t=1:
  - All outputs are 0 immediately and `busy` = 0.
  - No `done` is issued.
  - A fresh start after a reload produces the correct pattern.
- **Back-to-back feeds** (N=4, random data): `start` at the first IDLE cycle after `done` → the second result matches the reference product, and both `done` pulses are 3N+1 cycles after their `start`.

Source files
------------

// File: rtl/systolic_feeder_if.sv
// Bus bundle for the systolic array edge feeder: matrix write port, start
// request, skewed edge data and status.
interface systolic_feeder_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic                 wr_en;
  logic                 wr_sel;
  logic [$clog2(N)-1:0] wr_row;
  logic [$clog2(N)-1:0] wr_col;
  logic [W-1:0]         wr_data;
  logic                 start;
  logic [N*W-1:0]       a_west;
  logic [N*W-1:0]       b_north;
  logic                 array_en;
  logic                 busy;
  logic                 done;

  modport master (
    output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    input  a_west, b_north, array_en, busy, done
  );

  modport slave (
    input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    output a_west, b_north, array_en, busy, done
  );
endinterface

// File: rtl/systolic_feeder.sv
// Edge driver for an NxN output-stationary systolic MAC array: stores A and B,
// then streams skewed, zero-padded rows/columns into the west and north edges.
//
// state | meaning
// IDLE  | storage writable, waiting for start
// FEED  | driving step t = 0 .. 3N-1 onto the array edges
// DONE  | one-cycle done pulse, array disabled
module systolic_feeder #(
  parameter int N = 4,
  parameter int W = 8
) (
  input logic clk,
  input logic rst,
  systolic_feeder_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int TW = $clog2(3 * N);
  localparam logic [TW-1:0] T_LAST = TW'(3 * N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FEED = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state;
  logic [TW-1:0]  t;
  logic [W-1:0]   mem_a [N][N];
  logic [W-1:0]   mem_b [N][N];
  logic [N*W-1:0] a_step, b_step;
  logic [N*W-1:0] a_q, b_q;
  logic           en_q, busy_q, done_q;

  // Row i / column i is offset by i steps; anything outside the matrix is zero.
  always_comb begin
    int d;
    d      = 0;
    a_step = '0;
    b_step = '0;
    for (int i = 0; i < N; i++) begin
      d = int'(t) - i;
      if (d >= 0 && d < N) begin
        a_step[i*W +: W] = mem_a[i][d[IW-1:0]];
        b_step[i*W +: W] = mem_b[d[IW-1:0]][i];
      end
    end
  end

  // Storage only accepts writes in IDLE, so a running feed sees stable data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          mem_a[r][c] <= '0;
          mem_b[r][c] <= '0;
        end
      end
    end else if (bus.wr_en && state == IDLE) begin
      if (!bus.wr_sel) mem_a[bus.wr_row][bus.wr_col] <= bus.wr_data;
      else             mem_b[bus.wr_row][bus.wr_col] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      t      <= '0;
      a_q    <= '0;
      b_q    <= '0;
      en_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          a_q    <= '0;
          b_q    <= '0;
          en_q   <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          t      <= '0;
          if (bus.start) state <= FEED;
        end
        FEED: begin
          a_q    <= a_step;
          b_q    <= b_step;
          en_q   <= 1'b1;
          busy_q <= 1'b1;
          done_q <= 1'b0;
          if (t == T_LAST) state <= DONE;
          else             t     <= t + TW'(1);
        end
        DONE: begin
          a_q    <= '0;
          b_q    <= '0;
          en_q   <= 1'b0;
          busy_q <= 1'b1;
          done_q <= 1'b1;
          t      <= '0;
          state  <= IDLE;
        end
        default: begin
          a_q    <= '0;
          b_q    <= '0;
          en_q   <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          t      <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.a_west   = a_q;
  assign bus.b_north  = b_q;
  assign bus.array_en = en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: N=2 and N=4 instances, each feeding a
// behavioural output-stationary MAC mesh whose accumulators are checked at done.
module tb_systolic_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_feeder_if #(.N(2), .W(8)) bus2 ();
  systolic_feeder_if #(.N(4), .W(8)) bus4 ();

  systolic_feeder #(.N(2), .W(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
  systolic_feeder #(.N(4), .W(8)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int d2cnt = 0;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) d2cnt <= 0;
    else if (bus2.done) d2cnt <= d2cnt + 1;
  end

  // Behavioural mesh: A moves east, B moves south, each PE accumulates a*b.
  logic              clr2 = 1'b0;
  logic              clr4 = 1'b0;
  logic signed [7:0] ah2 [2][2];
  logic signed [7:0] bv2 [2][2];
  int                acc2 [2][2];
  logic signed [7:0] ah4 [4][4];
  logic signed [7:0] bv4 [4][4];
  int                acc4 [4][4];

  function automatic logic signed [7:0] ain2(input int i, input int j);
    if (j == 0) return signed'(bus2.a_west[i*8 +: 8]);
    return ah2[i][j-1];
  endfunction
  function automatic logic signed [7:0] bin2(input int i, input int j);
    if (i == 0) return signed'(bus2.b_north[j*8 +: 8]);
    return bv2[i-1][j];
  endfunction
  function automatic logic signed [7:0] ain4(input int i, input int j);
    if (j == 0) return signed'(bus4.a_west[i*8 +: 8]);
    return ah4[i][j-1];
  endfunction
  function automatic logic signed [7:0] bin4(input int i, input int j);
    if (i == 0) return signed'(bus4.b_north[j*8 +: 8]);
    return bv4[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        if (rst || clr2) begin
          acc2[i][j] <= 0;
          ah2[i][j]  <= '0;
          bv2[i][j]  <= '0;
        end else if (bus2.array_en) begin
          acc2[i][j] <= acc2[i][j] + ain2(i, j) * bin2(i, j);
          ah2[i][j]  <= ain2(i, j);
          bv2[i][j]  <= bin2(i, j);
        end
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (rst || clr4) begin
          acc4[i][j] <= 0;
          ah4[i][j]  <= '0;
          bv4[i][j]  <= '0;
        end else if (bus4.array_en) begin
          acc4[i][j] <= acc4[i][j] + ain4(i, j) * bin4(i, j);
          ah4[i][j]  <= ain4(i, j);
          bv4[i][j]  <= bin4(i, j);
        end
      end
    end
  end

  logic [7:0]  ma2 [2][2];
  logic [7:0]  mb2 [2][2];
  logic [15:0] ea2 [6];
  logic [15:0] eb2 [6];
  int          ec2 [4];
  logic [7:0]  ra4 [4][4];
  logic [7:0]  rb4 [4][4];
  int          c4  [4][4];

  // All stimulus tasks start and end just after a falling edge.
  task automatic w2(input logic sel, input int r, input int c, input logic [7:0] d);
    bus2.wr_en = 1'b1; bus2.wr_sel = sel; bus2.wr_row = r[0:0]; bus2.wr_col = c[0:0];
    bus2.wr_data = d;
    @(posedge clk); @(negedge clk);
    bus2.wr_en = 1'b0;
  endtask

  task automatic w4(input logic sel, input int r, input int c, input logic [7:0] d);
    bus4.wr_en = 1'b1; bus4.wr_sel = sel; bus4.wr_row = r[1:0]; bus4.wr_col = c[1:0];
    bus4.wr_data = d;
    @(posedge clk); @(negedge clk);
    bus4.wr_en = 1'b0;
  endtask

  task automatic load2();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        w2(1'b0, r, c, ma2[r][c]);
        w2(1'b1, r, c, mb2[r][c]);
      end
  endtask

  task automatic pulse_start2();
    bus2.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus2.start = 1'b0;
  endtask

  task automatic feed2(input string tag);
    clr2 = 1'b1;
    pulse_start2();
    clr2 = 1'b0;
    check({tag, "_busy_before"}, bus2.busy, 0);
    for (int t = 0; t < 6; t++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("%s_a_t%0d", tag, t), bus2.a_west, ea2[t]);
      check($sformatf("%s_b_t%0d", tag, t), bus2.b_north, eb2[t]);
      check($sformatf("%s_en_t%0d", tag, t), {bus2.array_en, bus2.busy, bus2.done}, 3'b110);
    end
    @(posedge clk); @(negedge clk);
    check({tag, "_done"}, {bus2.array_en, bus2.busy, bus2.done}, 3'b011);
    check({tag, "_done_data"}, {bus2.a_west, bus2.b_north}, 0);
    for (int k = 0; k < 4; k++)
      check($sformatf("%s_acc%0d%0d", tag, k / 2, k % 2), acc2[k/2][k%2], ec2[k]);
    @(posedge clk); @(negedge clk);
    check({tag, "_idle"}, {bus2.busy, bus2.done}, 2'b00);
  endtask

  task automatic run4(input string tag, input logic chain);
    int ks;
    clr4 = 1'b1;
    bus4.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus4.start = 1'b0;
    clr4 = 1'b0;
    ks = cyc;
    for (int n = 0; n < 60 && !bus4.done; n++) @(negedge clk);
    check({tag, "_done_seen"}, bus4.done, 1);
    check({tag, "_latency"}, cyc - ks, 13);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        check($sformatf("%s_c%0d%0d", tag, i, j), acc4[i][j], c4[i][j]);
    if (!chain) begin
      @(posedge clk); @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus2.wr_en = 0; bus2.wr_sel = 0; bus2.wr_row = '0; bus2.wr_col = '0;
    bus2.wr_data = '0; bus2.start = 0;
    bus4.wr_en = 0; bus4.wr_sel = 0; bus4.wr_row = '0; bus4.wr_col = '0;
    bus4.wr_data = '0; bus4.start = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out2", {bus2.a_west, bus2.b_north, bus2.array_en, bus2.busy, bus2.done}, 0);
    check("rst_out4", {bus4.a_west, bus4.b_north, bus4.array_en, bus4.busy, bus4.done}, 0);

    // Skew pattern and 2x2 end-to-end product
    ma2 = '{'{8'd1, 8'd2}, '{8'd3, 8'd4}};
    mb2 = '{'{8'd5, 8'd6}, '{8'd7, 8'd8}};
    load2();
    ea2 = '{16'h0001, 16'h0302, 16'h0400, 16'h0, 16'h0, 16'h0};
    eb2 = '{16'h0005, 16'h0607, 16'h0800, 16'h0, 16'h0, 16'h0};
    ec2 = '{19, 22, 43, 50};
    feed2("skew");

    // Signed extremes pass bit-exact
    ma2 = '{'{8'h80, 8'h80}, '{8'h80, 8'h80}};
    mb2 = '{'{8'h7F, 8'h7F}, '{8'h7F, 8'h7F}};
    load2();
    ea2 = '{16'h0080, 16'h8080, 16'h8000, 16'h0, 16'h0, 16'h0};
    eb2 = '{16'h007F, 16'h7F7F, 16'h7F00, 16'h0, 16'h0, 16'h0};
    ec2 = '{-32512, -32512, -32512, -32512};
    feed2("signed");

    // Write and start during FEED are both ignored
    ma2 = '{'{8'd1, 8'd2}, '{8'd3, 8'd4}};
    mb2 = '{'{8'd5, 8'd6}, '{8'd7, 8'd8}};
    load2();
    begin
      int snap;
      snap = d2cnt;
      pulse_start2();
      @(posedge clk); @(negedge clk);
      w2(1'b0, 0, 0, 8'd9);
      pulse_start2();
      repeat (20) @(negedge clk);
      check("ignored_one_done", d2cnt - snap, 1);
    end
    ea2 = '{16'h0001, 16'h0302, 16'h0400, 16'h0, 16'h0, 16'h0};
    eb2 = '{16'h0005, 16'h0607, 16'h0800, 16'h0, 16'h0, 16'h0};
    ec2 = '{19, 22, 43, 50};
    feed2("after_ignored");

    // Reset during FEED at t=1
    pulse_start2();
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("midrst_a_t1", bus2.a_west, 16'h0302);
    rst = 1'b1;
    #1;
    check("midrst_out", {bus2.a_west, bus2.b_north, bus2.array_en, bus2.done}, 0);
    check("midrst_busy", bus2.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("midrst_no_done", d2cnt, 0);
    pulse_start2();
    @(posedge clk); @(negedge clk);
    check("midrst_storage_clear", {bus2.a_west, bus2.b_north}, 0);
    repeat (10) @(negedge clk);
    load2();
    feed2("reload");

    // Back-to-back N=4 feeds on random data
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ra4[i][j] = 8'($urandom_range(0, 255));
        rb4[i][j] = 8'($urandom_range(0, 255));
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        c4[i][j] = 0;
        for (int k = 0; k < 4; k++)
          c4[i][j] += int'(signed'(ra4[i][k])) * int'(signed'(rb4[k][j]));
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        w4(1'b0, i, j, ra4[i][j]);
        w4(1'b1, i, j, rb4[i][j]);
      end
    run4("b2b_first", 1'b1);
    run4("b2b_second", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
